// File: rtl/decode_issue.sv
// decode_issue: byte-serial instruction assembly, RV32I OP/OP-IMM/LUI decode and
// a registered valid/ready ALU request.

package decode_issue_pkg;
  typedef enum logic [3:0] {
    Add,
    Subtract,
    Shift_Left_Logical,
    Shift_Right_Logical,
    Shift_Right_Arithmetic,
    Set_Less_Than,
    Set_Less_Than_Unsigned,
    Xor,
    Or,
    And
  } alu_operation_t;
endpackage

module decode_issue
  import decode_issue_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4:0]            rs1_addr,
  output logic [4:0]            rs2_addr,
  input  logic [31:0]           rs1_data,
  input  logic [31:0]           rs2_data,
  output alu_operation_t        operation,
  output logic signed [31:0]    operand_1,
  output logic signed [31:0]    operand_2,
  output logic [4:0]            rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  illegal
);

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] F7Zero   = 7'b0000000;
  localparam logic [6:0] F7Alt    = 7'b0100000;

  typedef enum logic [1:0] {StCollect, StRead, StIssue} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [31:0] instr;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] i_imm;
  logic [31:0] shamt;

  logic           dec_legal;
  alu_operation_t dec_op;
  logic [31:0]    dec_op1;
  logic [31:0]    dec_op2;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign in_ready = (state == StCollect);

  // Register x0 reads as zero whatever the register file returns.
  assign rs1_val  = (rs1_addr == 5'd0) ? 32'd0 : rs1_data;
  assign rs2_val  = (rs2_addr == 5'd0) ? 32'd0 : rs2_data;
  assign i_imm    = {{20{instr[31]}}, instr[31:20]};
  assign shamt    = {27'd0, instr[24:20]};

  // Decode the held instruction into operation, operands and legality.
  always_comb begin
    dec_legal = 1'b0;
    dec_op    = Add;
    dec_op1   = 32'd0;
    dec_op2   = 32'd0;
    case (opcode)
      OpcOp: begin
        dec_op1 = rs1_val;
        dec_op2 = rs2_val;
        case (funct3)
          3'b000: begin
            dec_legal = (funct7 == F7Zero) || (funct7 == F7Alt);
            dec_op    = (funct7 == F7Alt) ? Subtract : Add;
          end
          3'b001: begin dec_legal = (funct7 == F7Zero); dec_op = Shift_Left_Logical;     end
          3'b010: begin dec_legal = (funct7 == F7Zero); dec_op = Set_Less_Than;          end
          3'b011: begin dec_legal = (funct7 == F7Zero); dec_op = Set_Less_Than_Unsigned; end
          3'b100: begin dec_legal = (funct7 == F7Zero); dec_op = Xor;                    end
          3'b101: begin
            dec_legal = (funct7 == F7Zero) || (funct7 == F7Alt);
            dec_op    = (funct7 == F7Alt) ? Shift_Right_Arithmetic : Shift_Right_Logical;
          end
          3'b110:  begin dec_legal = (funct7 == F7Zero); dec_op = Or;  end
          default: begin dec_legal = (funct7 == F7Zero); dec_op = And; end
        endcase
      end
      OpcOpImm: begin
        dec_op1   = rs1_val;
        dec_op2   = i_imm;
        dec_legal = 1'b1;
        // Only the shifts constrain the upper immediate bits.
        case (funct3)
          3'b000: dec_op = Add;
          3'b001: begin
            dec_op    = Shift_Left_Logical;
            dec_op2   = shamt;
            dec_legal = (funct7 == F7Zero);
          end
          3'b010: dec_op = Set_Less_Than;
          3'b011: dec_op = Set_Less_Than_Unsigned;
          3'b100: dec_op = Xor;
          3'b101: begin
            dec_op    = (funct7 == F7Alt) ? Shift_Right_Arithmetic : Shift_Right_Logical;
            dec_op2   = shamt;
            dec_legal = (funct7 == F7Zero) || (funct7 == F7Alt);
          end
          3'b110:  dec_op = Or;
          default: dec_op = And;
        endcase
      end
      OpcLui: begin
        dec_legal = 1'b1;
        dec_op    = Add;
        dec_op1   = 32'd0;
        dec_op2   = {instr[31:12], 12'd0};
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Collect/read/issue FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StCollect;
      cnt       <= 2'd0;
      instr     <= 32'd0;
      operation <= Add;
      operand_1 <= 32'sd0;
      operand_2 <= 32'sd0;
      rd        <= 5'd0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      state     <= StCollect;
      cnt       <= 2'd0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state)
        StCollect: begin
          if (in_valid) begin
            instr[{cnt, 3'b000} +: 8] <= in_data;
            cnt                       <= cnt + 2'd1;
            if (cnt == 2'd3) state <= StRead;
          end
        end
        StRead: begin
          if (dec_legal) begin
            operation <= dec_op;
            operand_1 <= dec_op1;
            operand_2 <= dec_op2;
            rd        <= instr[11:7];
            out_valid <= 1'b1;
            state     <= StIssue;
          end else begin
            illegal <= 1'b1;
            state   <= StCollect;
          end
        end
        StIssue: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= StCollect;
          end
        end
        default: state <= StCollect;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: one task per scenario, inline checks.
module tb_decode_issue;
  import decode_issue_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                flush;
  logic [7:0]          in_data;
  logic                in_valid;
  logic                in_ready;
  logic [4:0]          rs1_addr;
  logic [4:0]          rs2_addr;
  logic [31:0]         rs1_data;
  logic [31:0]         rs2_data;
  alu_operation_t      operation;
  logic signed [31:0]  operand_1;
  logic signed [31:0]  operand_2;
  logic [4:0]          rd;
  logic                out_valid;
  logic                out_ready;
  logic                illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_issue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .operation (operation),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .rd        (rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .illegal   (illegal)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives four bytes, one per cycle; returns in the READ cycle (T+1).
  task automatic send_instr(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = w[8*i +: 8];
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (illegal !== 1'b0) begin errors++;
      $display("FAIL reset_illegal: got %b want 0", illegal); end
    checks++; if (operation !== Add) begin errors++;
      $display("FAIL reset_operation: got %0d want %0d", operation, Add); end
    checks++; if (operand_1 !== 32'sd0 || operand_2 !== 32'sd0) begin errors++;
      $display("FAIL reset_operands: got %h/%h want 0/0", operand_1, operand_2); end
    checks++; if (rd !== 5'd0 || rs1_addr !== 5'd0 || rs2_addr !== 5'd0) begin errors++;
      $display("FAIL reset_regs: got rd=%0d rs1=%0d rs2=%0d want 0", rd, rs1_addr, rs2_addr);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    rs1_data  = 32'd5;
    rs2_data  = 32'd7;
    out_ready = 1'b1;
    send_instr(32'h0020_8533);
    checks++; if (rs1_addr !== 5'd1 || rs2_addr !== 5'd2) begin errors++;
      $display("FAIL add_addr: got %0d/%0d want 1/2", rs1_addr, rs2_addr); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++;
      $display("FAIL add_read_cycle: got valid=%b ready=%b want 0/0", out_valid, in_ready); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++;
      $display("FAIL add_valid: got %b want 1", out_valid); end
    checks++; if (operation !== Add || operand_1 !== 32'sd5 || operand_2 !== 32'sd7
                  || rd !== 5'd10) begin errors++;
      $display("FAIL add_result: got op=%0d %h %h rd=%0d want %0d 5 7 rd=10",
               operation, operand_1, operand_2, rd, Add); end
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL add_after: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_sub_x0();
    rs1_data = 32'h0000_DEAD;
    rs2_data = 32'd9;
    send_instr(32'h4020_01B3);
    step();
    checks++; if (out_valid !== 1'b1 || operation !== Subtract || operand_1 !== 32'sd0
                  || operand_2 !== 32'sd9 || rd !== 5'd3) begin errors++;
      $display("FAIL sub_x0: got v=%b op=%0d %h %h rd=%0d want 1 %0d 0 9 3",
               out_valid, operation, operand_1, operand_2, rd, Subtract); end
    step();
  endtask

  task automatic test_srai_illegal();
    rs1_data = 32'h8000_1234;
    send_instr(32'h41F3_5293);
    step();
    checks++; if (out_valid !== 1'b1 || operation !== Shift_Right_Arithmetic
                  || operand_1 !== 32'sh8000_1234 || operand_2 !== 32'sd31
                  || rd !== 5'd5) begin errors++;
      $display("FAIL srai: got v=%b op=%0d %h %h rd=%0d want 1 %0d 80001234 1f 5",
               out_valid, operation, operand_1, operand_2, rd, Shift_Right_Arithmetic); end
    step();
    rs1_data = 32'h0000_0001;
    send_instr(32'h61F3_5293);
    checks++; if (illegal !== 1'b0) begin errors++;
      $display("FAIL illegal_early: got %b want 0", illegal); end
    step();
    checks++; if (illegal !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_pulse: got ill=%b v=%b rdy=%b want 1 0 1",
               illegal, out_valid, in_ready); end
    checks++; if (operation !== Shift_Right_Arithmetic || operand_2 !== 32'sd31
                  || operand_1 !== 32'sh8000_1234 || rd !== 5'd5) begin errors++;
      $display("FAIL illegal_hold: got op=%0d %h %h rd=%0d want unchanged",
               operation, operand_1, operand_2, rd); end
    step();
    checks++; if (illegal !== 1'b0 || out_valid !== 1'b0) begin errors++;
      $display("FAIL illegal_after: got ill=%b v=%b want 0 0", illegal, out_valid); end
  endtask

  task automatic test_addi_lui();
    rs1_data = 32'd100;
    send_instr(32'hFFF0_8093);
    step();
    checks++; if (operation !== Add || operand_1 !== 32'sd100
                  || operand_2 !== 32'shFFFF_FFFF || rd !== 5'd1) begin errors++;
      $display("FAIL addi: got op=%0d %h %h rd=%0d want %0d 64 ffffffff 1",
               operation, operand_1, operand_2, rd, Add); end
    step();
    rs1_data = 32'h0000_0055;
    send_instr(32'h1234_5137);
    step();
    checks++; if (out_valid !== 1'b1 || operation !== Add || operand_1 !== 32'sd0
                  || operand_2 !== 32'sh1234_5000 || rd !== 5'd2) begin errors++;
      $display("FAIL lui: got v=%b op=%0d %h %h rd=%0d want 1 %0d 0 12345000 2",
               out_valid, operation, operand_1, operand_2, rd, Add); end
    step();
  endtask

  task automatic test_back_to_back();
    // xor x4,x1,x2 stalled, then or x4,x1,x2 after release
    rs1_data  = 32'd3;
    rs2_data  = 32'd6;
    out_ready = 1'b0;
    send_instr(32'h0020_C233);
    step();
    rs1_data = 32'hFFFF_0000;
    in_valid = 1'b1;
    in_data  = 8'h33;
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || operation !== Xor
                    || operand_1 !== 32'sd3 || operand_2 !== 32'sd6 || rd !== 5'd4) begin
        errors++;
        $display("FAIL stall_%0d: got v=%b rdy=%b op=%0d %h %h rd=%0d want 1 0 %0d 3 6 4",
                 i, out_valid, in_ready, operation, operand_1, operand_2, rd, Xor); end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL release: got v=%b rdy=%b want 0 1", out_valid, in_ready); end
    rs1_data = 32'd3;
    send_instr(32'h0020_E233);
    step();
    checks++; if (out_valid !== 1'b1 || operation !== Or || operand_1 !== 32'sd3
                  || operand_2 !== 32'sd6) begin errors++;
      $display("FAIL after_stall: got v=%b op=%0d %h %h want 1 %0d 3 6",
               out_valid, operation, operand_1, operand_2, Or); end
    step();
  endtask

  task automatic test_flush();
    in_valid = 1'b1;
    in_data  = 8'hAA;
    step();
    in_data  = 8'hBB;
    step();
    flush   = 1'b1;
    in_data = 8'hCC;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    rs1_data = 32'd12;
    rs2_data = 32'd10;
    send_instr(32'h0020_F3B3);
    step();
    checks++; if (out_valid !== 1'b1 || operation !== And || rd !== 5'd7
                  || operand_1 !== 32'sd12 || operand_2 !== 32'sd10) begin errors++;
      $display("FAIL flush_partial: got v=%b op=%0d rd=%0d %h %h want 1 %0d 7 c a",
               out_valid, operation, rd, operand_1, operand_2, And); end
    step();
    // Unknown opcode, flushed during READ: illegal must not pulse.
    send_instr(32'h0000_007F);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (illegal !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_read: got ill=%b v=%b rdy=%b want 0 0 1",
               illegal, out_valid, in_ready); end
  endtask

  task automatic test_reset_issue();
    out_ready = 1'b0;
    rs1_data  = 32'd1;
    rs2_data  = 32'd2;
    send_instr(32'h0020_8533);
    step();
    checks++; if (out_valid !== 1'b1) begin errors++;
      $display("FAIL pre_reset_valid: got %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || operation !== Add || operand_1 !== 32'sd0
                  || rd !== 5'd0) begin errors++;
      $display("FAIL async_reset: got v=%b op=%0d %h rd=%0d want 0 %0d 0 0",
               out_valid, operation, operand_1, rd, Add); end
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    // Two stray bytes, reset, then a full lui x2,0x12345.
    in_valid = 1'b1;
    in_data  = 8'h11;
    step();
    step();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    send_instr(32'h1234_5137);
    step();
    checks++; if (out_valid !== 1'b1 || operand_2 !== 32'sh1234_5000 || rd !== 5'd2) begin
      errors++;
      $display("FAIL reset_partial: got v=%b %h rd=%0d want 1 12345000 2",
               out_valid, operand_2, rd); end
    step();
  endtask

  initial begin
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    rs1_data  = 32'd0;
    rs2_data  = 32'd0;
    out_ready = 1'b1;
    test_reset();
    test_add();
    test_sub_x0();
    test_srai_illegal();
    test_addi_lui();
    test_back_to_back();
    test_flush();
    test_reset_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
